// File: rtl/trs_sched_pkg.sv
// Shared types and helpers for the round-robin trs scheduler.
package trs_sched_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counts stick at max_v instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/trs_sched_trs.sv
// Truncate / round-half-up / saturate from a wide signed accumulator to a narrow sample.
module trs #(
    parameter int IN_WIDTH  = 36,
    parameter int OUT_WIDTH = 16,
    parameter int TRUNC     = 18
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        sat
);

    localparam int SUM_W = IN_WIDTH - TRUNC + 1;

    // One extra bit of headroom so the round-bit add cannot overflow.
    function automatic logic signed [SUM_W-1:0] round_half_up(input logic signed [IN_WIDTH-1:0] d);
        logic signed [SUM_W-1:0] kept;
        kept = {d[IN_WIDTH-1], d[IN_WIDTH-1:TRUNC]};
        return kept + {{(SUM_W-1){1'b0}}, d[TRUNC-1]};
    endfunction

    // Returns {sat, value}; in range only when all bits above the output sign agree.
    function automatic logic [OUT_WIDTH:0] saturate(input logic signed [SUM_W-1:0] v);
        logic [SUM_W-OUT_WIDTH:0] hi;
        hi = v[SUM_W-1:OUT_WIDTH-1];
        if ((&hi) || (~|hi))
            return {1'b0, v[OUT_WIDTH-1:0]};
        else if (v[SUM_W-1])
            return {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
    endfunction

    logic signed [SUM_W-1:0] rnd;

    assign rnd         = round_half_up(din);
    assign {sat, dout} = saturate(rnd);

endmodule

// File: rtl/trs_sched.sv
// Round-robin scheduler feeding NUM_CH requesters through one shared trs, with per-channel saturation counters.
module trs_sched
    import trs_sched_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int IN_WIDTH  = 36,
    parameter int OUT_WIDTH = 16,
    parameter int TRUNC     = 18,
    parameter int CNT_WIDTH = 16,
    localparam int CH_W     = ch_w(NUM_CH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_CH-1:0]             in_valid,
    input  logic [NUM_CH*IN_WIDTH-1:0]    in_data,
    output logic [NUM_CH-1:0]             in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic [CH_W-1:0]               out_ch,
    output logic                          out_sat,
    input  logic [NUM_CH-1:0]             sat_cnt_clr,
    output logic [NUM_CH*CNT_WIDTH-1:0]   sat_cnt
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);

    out_state_e                  state;
    logic [CH_W-1:0]             rr_ptr;
    logic [CH_W-1:0]             gnt_idx;
    logic [CH_W-1:0]             rr_nxt;
    logic                        gnt_found;
    logic                        can_take;
    logic                        xfer;
    logic signed [IN_WIDTH-1:0]  trs_din;
    logic signed [OUT_WIDTH-1:0] trs_dout;
    logic                        trs_sat;

    // Arbiter: first valid channel at or after rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_found && in_valid[(int'(rr_ptr) + k) % NUM_CH]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'((int'(rr_ptr) + k) % NUM_CH);
            end
        end
    end

    assign can_take  = (state == ST_EMPTY) || out_ready;
    assign xfer      = !rst && en && can_take && gnt_found;
    assign in_ready  = xfer ? (NUM_CH'(1) << gnt_idx) : '0;
    assign rr_nxt    = CH_W'((int'(gnt_idx) + 1) % NUM_CH);
    assign out_valid = (state == ST_FULL);

    always_comb begin
        trs_din = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == CH_W'(i))
                trs_din = in_data[i*IN_WIDTH +: IN_WIDTH];
        end
    end

    trs #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .TRUNC     (TRUNC)
    ) u_trs (
        .din  (trs_din),
        .dout (trs_dout),
        .sat  (trs_sat)
    );

    // Output stage: one result register, EMPTY/FULL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_EMPTY;
            rr_ptr   <= '0;
            out_data <= '0;
            out_ch   <= '0;
            out_sat  <= 1'b0;
        end else begin
            if (xfer) begin
                out_data <= trs_dout;
                out_sat  <= trs_sat;
                out_ch   <= gnt_idx;
                rr_ptr   <= rr_nxt;
            end
            case (state)
                ST_EMPTY: if (xfer) state <= ST_FULL;
                ST_FULL:  if (!xfer && out_ready) state <= ST_EMPTY;
                default:  state <= ST_EMPTY;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        logic                 inc;
        logic [CNT_WIDTH-1:0] cnt;

        assign inc = xfer && trs_sat && (gnt_idx == CH_W'(i));

        // A clear coinciding with an event keeps the event.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt <= '0;
            else if (sat_cnt_clr[i])
                cnt <= inc ? CNT_WIDTH'(1) : '0;
            else if (inc)
                cnt <= CNT_WIDTH'(sat_inc(32'(cnt), CNT_MAX));
        end

        assign sat_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
    end

endmodule

// File: tb/tb_trs_sched.sv
// Scoreboard bench for trs_sched: directed stimulus queues expected results, a monitor pops on each output handshake.
module tb_trs_sched;

    localparam int NUM_CH = 4;
    localparam int IN_W   = 36;
    localparam int OUT_W  = 16;
    localparam int CNT_W  = 16;

    localparam logic [IN_W-1:0] D_SINGLE = (36'd5 << 18) | (36'd1 << 17);
    localparam logic [IN_W-1:0] D_OVF    = 36'd40000 << 18;
    localparam logic [IN_W-1:0] D_NOVF   = 36'd0 - (36'd40000 << 18);
    localparam logic [IN_W-1:0] D_NEGRND = 36'd0 - (36'd5 << 18) + (36'd1 << 17);

    logic                      clk;
    logic                      rst;
    logic                      en;
    logic [NUM_CH-1:0]         in_valid;
    logic [NUM_CH*IN_W-1:0]    in_data;
    logic [NUM_CH-1:0]         in_ready;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [OUT_W-1:0]   out_data;
    logic [1:0]                out_ch;
    logic                      out_sat;
    logic [NUM_CH-1:0]         sat_cnt_clr;
    logic [NUM_CH*CNT_W-1:0]   sat_cnt;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [1:0]       ch;
        logic             sat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    trs_sched #(
        .NUM_CH    (NUM_CH),
        .IN_WIDTH  (IN_W),
        .OUT_WIDTH (OUT_W),
        .TRUNC     (18),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_sat     (out_sat),
        .sat_cnt_clr (sat_cnt_clr),
        .sat_cnt     (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [OUT_W-1:0] d, input logic [1:0] c, input logic s);
        exp_t e;
        e.data = d;
        e.ch   = c;
        e.sat  = s;
        exp_q.push_back(e);
    endtask

    task automatic set_data(input int ch, input logic [IN_W-1:0] v);
        in_data[ch*IN_W +: IN_W] = v;
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int i);
        return sat_cnt[i*CNT_W +: CNT_W];
    endfunction

    // Monitor: every accepted output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_unexpected: got data=0x%0h ch=%0d sat=%0d with nothing expected",
                         out_data, out_ch, out_sat);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_data !== e.data || out_ch !== e.ch || out_sat !== e.sat) begin
                    n_err++;
                    $display("FAIL out_result: got data=0x%0h ch=%0d sat=%0d expected data=0x%0h ch=%0d sat=%0d",
                             out_data, out_ch, out_sat, e.data, e.ch, e.sat);
                end
            end
        end
    end

    initial begin
        int n;
        int guard;

        rst         = 1'b1;
        en          = 1'b1;
        in_valid    = '1;
        in_data     = '0;
        out_ready   = 1'b1;
        sat_cnt_clr = '0;

        // Reset state, with requests pending that must stay ungranted.
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        in_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single sample on ch2 with round-up.
        set_data(2, D_SINGLE);
        in_valid = 4'b0100;
        push(16'd6, 2'd2, 1'b0);
        @(negedge clk);
        check("single_in_ready", in_ready, 4'b0100);
        @(posedge clk); #1;
        in_valid = '0;
        check("single_latency", out_valid, 1);
        @(posedge clk); #1;
        check("single_cnt2", cnt_of(2), 0);

        // Positive overflow on ch1.
        set_data(1, D_OVF);
        in_valid = 4'b0010;
        push(16'd32767, 2'd1, 1'b1);
        @(negedge clk);
        check("ovf_in_ready", in_ready, 4'b0010);
        @(posedge clk); #1;
        in_valid = '0;
        check("ovf_out_sat", out_sat, 1);
        check("ovf_cnt1", cnt_of(1), 1);

        // Bring rr_ptr back to 0 via a ch3 grant.
        set_data(3, '0);
        in_valid = 4'b1000;
        push(16'd0, 2'd3, 1'b0);
        @(negedge clk);
        check("pre_in_ready", in_ready, 4'b1000);
        @(posedge clk); #1;

        // Fairness: all channels valid, 12 back-to-back grants.
        set_data(0, 36'd1 << 18);
        set_data(1, (36'd2 << 18) | (36'd1 << 17));
        set_data(2, (36'd3 << 18) | ((36'd1 << 17) - 36'd1));
        set_data(3, D_NOVF);
        in_valid = 4'b1111;
        for (int r = 0; r < 3; r++) begin
            push(16'd1, 2'd0, 1'b0);
            push(16'd3, 2'd1, 1'b0);
            push(16'd3, 2'd2, 1'b0);
            push(16'h8000, 2'd3, 1'b1);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("fair_grant", in_ready, 64'(1) << (k % 4));
            @(posedge clk);
        end
        #1;
        in_valid = '0;
        check("fair_cnt3", cnt_of(3), 3);
        @(posedge clk); #1;

        // Backpressure: hold ch0 result for 5 cycles with ch1 waiting.
        set_data(0, 36'd7 << 18);
        set_data(1, 36'd9 << 18);
        in_valid  = 4'b0011;
        out_ready = 1'b0;
        push(16'd7, 2'd0, 1'b0);
        push(16'd9, 2'd1, 1'b0);
        @(negedge clk);
        check("bp_first_grant", in_ready, 4'b0001);
        @(posedge clk); #1;
        in_valid = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 7);
            check("bp_out_ch", out_ch, 0);
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", in_ready, 4'b0010);
        @(posedge clk); #1;
        in_valid = '0;

        // Drive ch0 counter to all-ones, then one more overflow.
        set_data(0, D_OVF);
        in_valid = 4'b0001;
        for (int k = 0; k < 65537; k++) push(16'd32767, 2'd0, 1'b1);
        n = 0;
        guard = 0;
        while (n < 65535 && guard < 70000) begin
            @(negedge clk);
            guard++;
            if (in_ready[0]) n++;
            @(posedge clk);
        end
        #1;
        check("cnt_fill_grants", n, 65535);
        check("cnt_at_max", cnt_of(0), 16'hFFFF);
        @(negedge clk);
        check("cnt_stick_grant", in_ready, 4'b0001);
        @(posedge clk); #1;
        check("cnt_stick", cnt_of(0), 16'hFFFF);

        // Clear together with an overflow event, then clear alone.
        sat_cnt_clr = 4'b0001;
        @(negedge clk);
        check("clr_inc_grant", in_ready, 4'b0001);
        @(posedge clk); #1;
        sat_cnt_clr = '0;
        in_valid    = '0;
        check("clr_with_inc", cnt_of(0), 1);
        sat_cnt_clr = 4'b0001;
        @(posedge clk); #1;
        sat_cnt_clr = '0;
        check("clr_alone", cnt_of(0), 0);
        @(posedge clk); #1;

        // Async reset while FULL with rr_ptr at 3.
        out_ready = 1'b0;
        set_data(2, 36'd11 << 18);
        in_valid = 4'b0100;
        @(negedge clk);
        check("rst_pre_grant", in_ready, 4'b0100);
        @(posedge clk); #1;
        set_data(1, D_NEGRND);
        set_data(3, 36'd2 << 18);
        in_valid = 4'b1010;
        @(negedge clk);
        check("rst_pre_full", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_ch", out_ch, 0);
        check("arst_sat_cnt", sat_cnt, 0);
        check("arst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        check("arst_hold_in_ready", in_ready, 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        push(16'hFFFC, 2'd1, 1'b0);
        @(negedge clk);
        check("post_rst_grant", in_ready, 4'b0010);
        @(posedge clk); #1;
        in_valid = '0;

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
